// File: rtl/arm_multicycle_controller.sv
// arm_multicycle_controller
//   Multicycle ARM control unit: per-instruction FSM, NZCV flag register with
//   condition evaluation, and an optional fixed-latency multiply wait path.
//   Drives every enable and mux select of the shared datapath each cycle.
// Parameters
//   MUL_EN       1 = decode MUL and use MULWAIT; 0 = MUL encodings act as AND
//   MUL_LATENCY  number of MULWAIT cycles (>= 1) before product write-back
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   Instr        IR contents (valid from DECODE onward)
//   ALUFlags     {N,Z,C,V} from the ALU this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, RegSrc, ImmSrc   mux selects
//   ALUControl   0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR
//   MulStart     one-cycle multiplier start pulse
//   State        current FSM state (debug)
module arm_multicycle_controller #(
  parameter bit          MUL_EN      = 1'b1,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        MulStart,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_MULWAIT = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_EOR = 4'd4;

  localparam int unsigned CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);

  // Registered per-state controls. The *_en / pc_cond bits are qualified by
  // CondEx combinationally so they track the flags of the current cycle.
  typedef struct packed {
    logic       pc_always;
    logic       pc_cond;
    logic       adr_src;
    logic       mem_wr_en;
    logic       ir_write;
    logic       reg_wr_en;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [3:0] alu_control;
    logic       mul_start;
  } ctrl_t;

  state_t        state, next_state;
  ctrl_t         ctrl_q;
  logic [3:0]    flags;
  logic [CW-1:0] mul_cnt;

  logic [1:0] op;
  logic [3:0] cmd;
  logic       s_bit;
  logic       is_mul;
  logic       is_cmp;
  logic [3:0] alu_op;
  logic       cond_ex;
  logic       unused_bits;

  assign op     = Instr[27:26];
  assign cmd    = Instr[24:21];
  assign s_bit  = Instr[20];
  assign is_cmp = (cmd == 4'b1010);
  assign is_mul = MUL_EN && (op == 2'b00) && !Instr[25] && (cmd == 4'b0000)
                  && (Instr[7:4] == 4'b1001);
  assign unused_bits = ^{Instr[19:8], Instr[3:0]};

  always_comb begin
    case (cmd)
      4'b0100: alu_op = ALU_ADD;
      4'b0010: alu_op = ALU_SUB;
      4'b1010: alu_op = ALU_SUB;
      4'b0000: alu_op = ALU_AND;
      4'b1100: alu_op = ALU_ORR;
      4'b0001: alu_op = ALU_EOR;
      default: alu_op = ALU_ADD;
    endcase
  end

  // ARM condition table on the registered flags {N,Z,C,V}
  always_comb begin
    case (Instr[31:28])
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = !flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = !flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = !flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = !flags[0];
      4'b1000: cond_ex = flags[1] && !flags[2];
      4'b1001: cond_ex = !flags[1] || flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = !flags[2] && (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] || (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   next_state = S_MEMADR;
          2'b10:   next_state = S_BRANCH;
          2'b00:   next_state = Instr[25] ? S_EXECI
                              : (is_mul ? S_MULWAIT : S_EXECR);
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = Instr[20] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = S_MEMWB;
      S_EXECR:   next_state = S_ALUWB;
      S_EXECI:   next_state = S_ALUWB;
      S_MULWAIT: next_state = (mul_cnt == MUL_LAST) ? S_ALUWB : S_MULWAIT;
      default:   next_state = S_FETCH;
    endcase
  end

  // Controls for state st; from_mul is high when the FSM is currently in
  // MULWAIT, which both selects the product in ALUWB and suppresses MulStart
  // after the first MULWAIT cycle.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic from_mul,
                                        input logic [3:0] aop, input logic cmp);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_always  = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_MEMADR: begin
        c.alu_src_b = 2'b01;
        c.imm_src   = 2'b01;
      end
      S_MEMRD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_wr_en  = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src   = 1'b1;
        c.mem_wr_en = 1'b1;
      end
      S_EXECR, S_EXECI: c.alu_control = aop;
      S_ALUWB: begin
        c.result_src = from_mul ? 2'b11 : 2'b00;
        c.reg_wr_en  = !cmp;
      end
      S_BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.imm_src    = 2'b10;
        c.result_src = 2'b10;
        c.pc_cond    = 1'b1;
      end
      S_MULWAIT: c.mul_start = !from_mul;
      default: ;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      flags   <= '0;
      mul_cnt <= '0;
      ctrl_q  <= decode_ctrl(S_FETCH, 1'b0, ALU_ADD, 1'b0);
    end else begin
      state  <= next_state;
      ctrl_q <= decode_ctrl(next_state, state == S_MULWAIT, alu_op, is_cmp);
      if (state == S_MULWAIT && next_state == S_MULWAIT)
        mul_cnt <= mul_cnt + 1'b1;
      else
        mul_cnt <= '0;
      if ((state == S_EXECR || state == S_EXECI) && cond_ex && (s_bit || is_cmp)) begin
        flags[3:2] <= ALUFlags[3:2];
        if (alu_op == ALU_ADD || alu_op == ALU_SUB)
          flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Write enables are gated by reset so they drop as soon as reset asserts.
  always_comb begin
    PCWrite    = reset && (ctrl_q.pc_always || (ctrl_q.pc_cond && cond_ex));
    IRWrite    = reset && ctrl_q.ir_write;
    RegWrite   = reset && ctrl_q.reg_wr_en && cond_ex;
    MemWrite   = reset && ctrl_q.mem_wr_en && cond_ex;
    MulStart   = reset && ctrl_q.mul_start;
    AdrSrc     = ctrl_q.adr_src;
    ResultSrc  = ctrl_q.result_src;
    ALUSrcA    = ctrl_q.alu_src_a;
    ALUSrcB    = ctrl_q.alu_src_b;
    ImmSrc     = ctrl_q.imm_src;
    ALUControl = ctrl_q.alu_control;
    RegSrc     = {op == 2'b01, op == 2'b10};
    State      = state;
  end

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// tb_arm_multicycle_controller
//   Self-checking bench: directed instruction sequences followed by random
//   instructions, compared each cycle against a per-instruction state-sequence
//   model with its own flag register.
module tb_arm_multicycle_controller;
  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, MulStart;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, RegSrc, ImmSrc;
  logic [3:0]  ALUControl, State;
  logic [19:0] obs;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [3:0]  m_flags;

  arm_multicycle_controller #(.MUL_EN(1'b1), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .MulStart(MulStart), .State(State)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, RegSrc, ImmSrc, ALUControl, MulStart};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Condition pairs: even code tests a predicate, odd code its negation.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0]) r = !r;
    if (c == 4'hF) r = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 4'd1;
      4'b0000: return 4'd2;
      4'b1100: return 4'd3;
      4'b0001: return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [19:0] exp_vec(input int st, input logic [31:0] ins,
                                          input logic [3:0] f, input bit mul_first,
                                          input bit from_mul);
    logic pcw, adr, memw, irw, regw, mst;
    logic [1:0] res, sa, sb, rs, imm;
    logic [3:0] ac;
    bit ce;
    ce = cond_holds(ins[31:28], f);
    pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; mst = 0;
    res = 0; sa = 0; sb = 0; imm = 0; ac = 0;
    rs = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
    case (st)
      0:  begin irw = 1; sa = 2'b01; sb = 2'b10; res = 2'b10; pcw = 1; end
      1:  begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
      2:  begin sb = 2'b01; imm = 2'b01; end
      3:  adr = 1;
      4:  begin res = 2'b01; regw = ce; end
      5:  begin adr = 1; memw = ce; end
      6, 7: ac = alu_of(ins[24:21]);
      8:  begin res = from_mul ? 2'b11 : 2'b00; regw = ce && (ins[24:21] != 4'b1010); end
      9:  begin sb = 2'b01; imm = 2'b10; res = 2'b10; pcw = ce; end
      10: mst = mul_first;
      default: ;
    endcase
    return {pcw, adr, memw, irw, regw, res, sa, sb, rs, imm, ac, mst};
  endfunction

  // Expected state sequence for one instruction, then cycle-by-cycle compare.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input bit rnd_af);
    int seq[$];
    int prev;
    logic [1:0] op;
    bit is_mul;
    op = ins[27:26];
    is_mul = (op == 2'b00) && !ins[25] && (ins[24:21] == 4'b0000) && (ins[7:4] == 4'b1001);
    seq = {0, 1};
    if (op == 2'b01) begin
      seq.push_back(2);
      if (ins[20]) begin seq.push_back(3); seq.push_back(4); end
      else seq.push_back(5);
    end else if (op == 2'b10) begin
      seq.push_back(9);
    end else if (ins[25]) begin
      seq.push_back(7); seq.push_back(8);
    end else if (is_mul) begin
      repeat (LAT) seq.push_back(10);
      seq.push_back(8);
    end else begin
      seq.push_back(6); seq.push_back(8);
    end
    prev = -1;
    foreach (seq[k]) begin
      @(negedge clk);
      Instr = ins;
      ALUFlags = rnd_af ? 4'($urandom) : af;
      #1;
      check($sformatf("state[%h.%0d]", ins, k), 32'(State), 32'(seq[k]));
      check($sformatf("ctrl[%h.s%0d]", ins, seq[k]), 32'(obs),
            32'(exp_vec(seq[k], ins, m_flags, seq[k] == 10 && prev != 10, prev == 10)));
      if ((seq[k] == 6 || seq[k] == 7) && cond_holds(ins[31:28], m_flags)
          && (ins[20] || ins[24:21] == 4'b1010)) begin
        m_flags[3:2] = ALUFlags[3:2];
        if (alu_of(ins[24:21]) <= 4'd1) m_flags[1:0] = ALUFlags[1:0];
      end
      prev = seq[k];
    end
  endtask

  function automatic logic [3:0] pick_cmd(input int unsigned i);
    case (i)
      0: return 4'b0100;
      1: return 4'b0010;
      2: return 4'b1010;
      3: return 4'b0000;
      4: return 4'b1100;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[27:26] = 2'b01;
      1: r[27:26] = 2'b10;
      2: begin r[27:26] = 2'b00; r[24:21] = pick_cmd($urandom_range(0, 5)); end
      default: begin
        r[27:26] = 2'b00; r[25] = 1'b0; r[24:21] = 4'b0000; r[7:4] = 4'b1001;
      end
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b0; Instr = '0; ALUFlags = '0; m_flags = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 32'(State), 32'd0);
    check("rst_wen", 32'({PCWrite, IRWrite, RegWrite, MemWrite, MulStart}), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    run_instr(32'hE0810002, 4'h0, 1'b0);   // ADD
    run_instr(32'hE5910004, 4'h0, 1'b0);   // LDR
    run_instr(32'hE5810004, 4'h0, 1'b0);   // STR
    run_instr(32'hE1500001, 4'b0100, 1'b0); // CMP -> Z
    run_instr(32'h0A000002, 4'h0, 1'b0);   // BEQ taken
    run_instr(32'hE1500001, 4'b0000, 1'b0); // CMP -> clear
    run_instr(32'h0A000002, 4'h0, 1'b0);   // BEQ not taken
    run_instr(32'hE1500001, 4'b0100, 1'b0); // CMP -> Z
    run_instr(32'h10810002, 4'b0000, 1'b0); // ADDNE suppressed
    run_instr(32'h0A000002, 4'h0, 1'b0);   // BEQ still taken
    run_instr(32'hE0000291, 4'h0, 1'b0);   // MUL

    for (int i = 0; i < 400; i++) run_instr(rand_instr(), 4'h0, 1'b1);

    // Reset asserted mid-STR while in MEMWR.
    begin
      int sseq[4];
      sseq = '{0, 1, 2, 5};
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        Instr = 32'hE5810004; ALUFlags = 4'h0;
        #1;
        check("rs_state", 32'(State), 32'(sseq[k]));
        check("rs_ctrl", 32'(obs), 32'(exp_vec(sseq[k], 32'hE5810004, m_flags, 1'b0, 1'b0)));
      end
      #1 reset = 1'b0;
      #1;
      check("rs_memwrite", 32'(MemWrite), 32'd0);
      check("rs_state0", 32'(State), 32'd0);
      check("rs_wen", 32'({PCWrite, IRWrite, RegWrite, MulStart}), 32'd0);
      m_flags = '0;
      @(posedge clk); #1 reset = 1'b1;
    end
    run_instr(32'h0A000002, 4'h0, 1'b0);   // flags cleared: BEQ not taken
    run_instr(32'hE0810002, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arm_multicycle_controller.md
# arm_multicycle_controller

Control unit for the multicycle ARM datapath. It is the successor to the single-cycle controller, which only decodes: this block adds a per-instruction state machine, a flag register with condition evaluation, and an optional stall-counted multiply path. It sits beside the shared datapath (register file, ALU, unified instruction/data memory, IR, multiplier) and drives every enable and mux select each cycle.

## Interface
- MUL_EN, 1, enables MUL decode and the MULWAIT state; when 0, MUL encodings are treated as AND.
- MUL_LATENCY, 3, number of MULWAIT cycles (≥1) before the product is written back.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  IR contents; valid from DECODE onward.
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult register.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  IR load enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result mux select: 00 = ALUOut register, 01 = Data register, 10 = ALU direct, 11 = multiplier product.
- ALUSrcA  out  2  ALU A select: 00 = RD1, 01 = PC.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- RegSrc  out  2  register-read address selects, same encoding as the single-cycle core.
- ImmSrc  out  2  extender mode: 00 = imm8, 01 = imm12, 10 = imm24.
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR.
- MulStart  out  1  one-cycle pulse that starts the multiplier.
- State  out  4  current FSM state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, MULWAIT 10.
- Transitions:
  - FETCH → DECODE.
  - DECODE branches on op = Instr[27:26]:
    - 01 → MEMADR.
    - 10 → BRANCH.
    - 00 with Instr[25] = 1 → EXECI.
    - 00 with Instr[25] = 0: if MUL (MUL_EN, Instr[24:21] = 0000, Instr[7:4] = 1001) → MULWAIT, else → EXECR.
  - MEMADR → MEMRD if L = Instr[20] = 1, else → MEMWR.
  - MEMRD → MEMWB.
  - EXECR and EXECI → ALUWB.
  - MULWAIT → ALUWB when the counter reaches MUL_LATENCY−1.
  - MEMWB, MEMWR, ALUWB and BRANCH → FETCH.
  - Encodings 11–15 → FETCH.
- Per-state outputs. Every output not listed below is 0.
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 01, ALUSrcB 10, ADD, ResultSrc 10, PCWrite 1.
  - DECODE: ALUSrcA 01, ALUSrcB 10, ADD, ResultSrc 10. The PC+8 operand is read here.
  - MEMADR: ALUSrcB 01, ADD, ImmSrc 01.
  - MEMRD: AdrSrc 1.
  - MEMWB: ResultSrc 01, RegWrite = CondEx.
  - MEMWR: AdrSrc 1, MemWrite = CondEx.
  - EXECR / EXECI: ALUControl decoded from cmd = Instr[24:21]:
    - 0100 ADD, 0010 SUB, 1010 CMP (SUB), 0000 AND, 1100 ORR, 0001 EOR.
    - Any other cmd decodes as ADD.
  - ALUWB: ResultSrc 00 (11 if entered from MULWAIT), RegWrite = CondEx & ~CMP.
  - BRANCH: ALUSrcB 01, ImmSrc 10, ADD, ResultSrc 10, PCWrite = CondEx.
  - MULWAIT: MulStart 1 in its first cycle only.
- ImmSrc is 00 in EXECI. RegSrc = {op==01, op==10} in every state.
- Condition evaluation: CondEx is computed combinationally from Instr[31:28] and the registered Flags, using the full ARM table EQ…AL; cond 1111 gives CondEx 0.
- Flag updates happen at the end of EXECR/EXECI, only when S = Instr[20] is set and CondEx is true:
  - NZ are loaded for all ALU ops.
  - CV are loaded only for ADD/SUB/CMP.
  - CMP updates flags regardless of S.
  - MUL never updates flags.

## Timing
- While reset = 0: State = FETCH, Flags = 0000, MUL counter = 0, and all write enables (PCWrite, IRWrite, RegWrite, MemWrite, MulStart) are forced to 0.
- The first FETCH takes effect on the first rising edge after reset deasserts.
- Cycles per instruction:
  - LDR: 5.
  - STR: 4.
  - Data-processing: 4.
  - Branch: 3.
  - MUL: 3 + MUL_LATENCY.
- All outputs are Moore-style from registered state, except CondEx-gated enables, which are combinational in their own state.
- Flags written at the end of EXECR/EXECI are visible to CondEx from the following cycle, so they apply to the same instruction's ALUWB.
- When a reset assertion lands mid-instruction, the FSM returns to FETCH immediately and no pending write completes.

## Test plan
- Reset, then release with Instr = 0xE0810002 (ADD R0,R1,R2) → states 0,1,6,8,0; ALUControl 0000 in state 6; RegWrite 1 in state 8; PCWrite 1 only in state 0.
- Instr = 0xE5910004 (LDR) → states 0,1,2,3,4; AdrSrc 1 in state 3; ResultSrc 01 and RegWrite 1 in state 4. Instr = 0xE5810004 (STR) → state 5 with MemWrite 1.
- CMP with ALUFlags = 0100 (Z), then 0x0A000002 (BEQ) → PCWrite 1 in BRANCH. Repeat with ALUFlags = 0000 → PCWrite 0.
- 0x10810002 (ADDNE) with Flags Z = 1 → RegWrite stays 0 in ALUWB; Flags unchanged.
- MUL_EN = 1, MUL_LATENCY = 3, Instr = 0xE0000291 → MULWAIT for 3 cycles with MulStart high only in the first; then ALUWB with ResultSrc 11.
- Assert reset during MEMWR → MemWrite drops to 0 asynchronously; State = 0.
